// File: rtl/b8_jump_pkg.sv
// ============================================================================
// Module      : b8_jump_pkg
// Description : Shared types and default constants for the jump redirect
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package b8_jump_pkg;

    localparam int c_default_num_ways = 2;
    localparam int c_default_addr_w   = 32;
    localparam int c_default_pid_w    = 2;
    localparam int c_default_flush    = 2;
    localparam int c_cnt_w            = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                        flag;
        logic [c_default_addr_w-1:0] addr;
        logic [c_default_pid_w-1:0]  pID;
    } jump_req_t;

endpackage

`default_nettype wire

// File: rtl/jump_age_sel.sv
// ============================================================================
// Module      : jump_age_sel
// Description : Combinational oldest-jump selector. Age is the modular
//               distance from the head ID; ties go to the lowest way index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_age_sel
    import b8_jump_pkg::*;
#(
    parameter int NUM_WAYS = c_default_num_ways,
    parameter int ADDR_W   = c_default_addr_w,
    parameter int PID_W    = c_default_pid_w,
    localparam int IDX_W   = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]             i_flags,
    input  logic [NUM_WAYS-1:0][ADDR_W-1:0] i_addrs,
    input  logic [NUM_WAYS-1:0][PID_W-1:0]  i_pids,
    input  logic [PID_W-1:0]                i_head,
    output logic                            o_found,
    output logic [IDX_W-1:0]                o_win_idx,
    output logic [ADDR_W-1:0]               o_win_addr,
    output logic [PID_W-1:0]                o_win_pid
);

    logic [PID_W-1:0]  w_age [NUM_WAYS];
    logic              w_found;
    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_addr;
    logic [PID_W-1:0]  w_pid;
    logic [PID_W-1:0]  w_best_age;

    // Truncation to PID_W bits performs the modulo on ID wrap-around.
    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_age
        assign w_age[i] = i_pids[i] - i_head;
    end

    always_comb begin
        w_found    = 1'b0;
        w_idx      = '0;
        w_addr     = '0;
        w_pid      = '0;
        w_best_age = '0;
        // Strict less-than keeps the lowest index on equal ages.
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (i_flags[i] && (!w_found || (w_age[i] < w_best_age))) begin
                w_found    = 1'b1;
                w_idx      = IDX_W'(i);
                w_addr     = i_addrs[i];
                w_pid      = i_pids[i];
                w_best_age = w_age[i];
            end
        end
    end

    assign o_found    = w_found;
    assign o_win_idx  = w_idx;
    assign o_win_addr = w_addr;
    assign o_win_pid  = w_pid;

endmodule

`default_nettype wire

// File: rtl/jump_redirect_arb.sv
// ============================================================================
// Module      : jump_redirect_arb
// Description : Arbitrates per-way jump reports into one fetch redirect,
//               keeps the oldest pending, flushes younger ways on accept.
//               Optional JUMP_ARB_STATS_EN adds redirect/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_redirect_arb
    import b8_jump_pkg::*;
#(
    parameter int NUM_WAYS  = c_default_num_ways,
    parameter int ADDR_W    = c_default_addr_w,
    parameter int PID_W     = c_default_pid_w,
    parameter int FLUSH_CYC = c_default_flush
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WAYS-1:0]             jumpFlag_i,
    input  logic [NUM_WAYS-1:0][ADDR_W-1:0] jumpAddr_i,
    input  logic [NUM_WAYS-1:0][PID_W-1:0]  EU_pID_i,
    input  logic [PID_W-1:0]                head_pID_i,
    output logic                            redirValid_o,
    input  logic                            redirReady_i,
    output logic [ADDR_W-1:0]               redirAddr_o,
    output logic [PID_W-1:0]                redirPID_o,
    output logic [NUM_WAYS-1:0]             wayFlush_o,
    output logic                            busy_o
`ifdef JUMP_ARB_STATS_EN
    ,
    output logic [31:0]                     redirCnt_o,
    output logic [31:0]                     dropCnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_WAYS);
    localparam logic [c_cnt_w-1:0] c_flush_load = c_cnt_w'(FLUSH_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [PID_W-1:0]   r_pid;

    logic               w_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [PID_W-1:0]   w_win_pid;
    logic [PID_W-1:0]   w_age [NUM_WAYS];
    logic [PID_W-1:0]   w_win_age;
    logic [PID_W-1:0]   w_pend_age;
    logic               w_pend;
    logic               w_accept;
    logic               w_replace;

    jump_age_sel #(
        .NUM_WAYS (NUM_WAYS),
        .ADDR_W   (ADDR_W),
        .PID_W    (PID_W)
    ) u_age_sel (
        .i_flags    (jumpFlag_i),
        .i_addrs    (jumpAddr_i),
        .i_pids     (EU_pID_i),
        .i_head     (head_pID_i),
        .o_found    (w_found),
        .o_win_idx  (w_win_idx),
        .o_win_addr (w_win_addr),
        .o_win_pid  (w_win_pid)
    );

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_age
        assign w_age[i] = EU_pID_i[i] - head_pID_i;
    end

    // Pending age is re-measured every cycle since the head keeps retiring.
    assign w_win_age  = w_age[w_win_idx];
    assign w_pend_age = r_pid - head_pID_i;
    assign w_pend     = (r_state == PEND);
    assign w_accept   = w_pend && redirReady_i;
    assign w_replace  = w_pend && w_found && (w_win_age < w_pend_age);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_found) w_next_state = PEND;
            PEND:    if (w_accept) w_next_state = FLUSH;
            FLUSH:   if (r_cnt <= c_cnt_one) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Acceptance wins over replacement: a younger-than-head winner arriving
    // on the accept cycle is on the wrong path and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_pid  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_addr <= w_win_addr;
                        r_pid  <= w_win_pid;
                    end
                end
                PEND: begin
                    if (w_accept) begin
                        r_cnt <= c_flush_load;
                    end else if (w_replace) begin
                        r_addr <= w_win_addr;
                        r_pid  <= w_win_pid;
                    end
                end
                FLUSH: begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_flush
        assign wayFlush_o[i] = w_accept && (w_age[i] > w_pend_age);
    end

    assign redirValid_o = w_pend;
    assign redirAddr_o  = r_addr;
    assign redirPID_o   = r_pid;
    assign busy_o       = (r_state != IDLE);

`ifdef JUMP_ARB_STATS_EN
    logic [31:0] r_redir_cnt;
    logic [31:0] r_drop_cnt;

    // Every winner seen while pending either displaces the held redirect or
    // is discarded, so each counts as one drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redir_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_accept && (r_redir_cnt != '1)) begin
                r_redir_cnt <= r_redir_cnt + 32'd1;
            end
            if (w_pend && w_found && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign redirCnt_o = r_redir_cnt;
    assign dropCnt_o  = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jump_redirect_arb.sv
// ============================================================================
// Module      : tb_jump_redirect_arb
// Description : Self-checking bench for jump_redirect_arb: directed vector
//               table, hand sequences and randomized reference-model run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_redirect_arb;
    import b8_jump_pkg::*;

    localparam int NW = 2;
    localparam int AW = 32;
    localparam int PW = 2;
    localparam int FC = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NW-1:0]           jumpFlag_i;
    logic [NW-1:0][AW-1:0]   jumpAddr_i;
    logic [NW-1:0][PW-1:0]   EU_pID_i;
    logic [PW-1:0]           head_pID_i;
    logic                    redirValid_o;
    logic                    redirReady_i;
    logic [AW-1:0]           redirAddr_o;
    logic [PW-1:0]           redirPID_o;
    logic [NW-1:0]           wayFlush_o;
    logic                    busy_o;
`ifdef JUMP_ARB_STATS_EN
    logic [31:0]             redirCnt_o;
    logic [31:0]             dropCnt_o;
`endif

    always #5 clk = ~clk;

    jump_redirect_arb #(
        .NUM_WAYS  (NW),
        .ADDR_W    (AW),
        .PID_W     (PW),
        .FLUSH_CYC (FC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jumpFlag_i   (jumpFlag_i),
        .jumpAddr_i   (jumpAddr_i),
        .EU_pID_i     (EU_pID_i),
        .head_pID_i   (head_pID_i),
        .redirValid_o (redirValid_o),
        .redirReady_i (redirReady_i),
        .redirAddr_o  (redirAddr_o),
        .redirPID_o   (redirPID_o),
        .wayFlush_o   (wayFlush_o),
        .busy_o       (busy_o)
`ifdef JUMP_ARB_STATS_EN
        ,
        .redirCnt_o   (redirCnt_o),
        .dropCnt_o    (dropCnt_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] flg, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [1:0] p0, input logic [1:0] p1,
                         input logic [1:0] head, input logic rdy);
        rst           = r;
        jumpFlag_i    = flg;
        jumpAddr_i[0] = a0;
        jumpAddr_i[1] = a1;
        EU_pID_i[0]   = p0;
        EU_pID_i[1]   = p1;
        head_pID_i    = head;
        redirReady_i  = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  flg;
        logic [31:0] a0, a1;
        logic [1:0]  p0, p1, head;
        logic        rdy;
        logic        v;
        logic [31:0] addr;
        logic [1:0]  pid;
        logic [1:0]  wf;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] flg, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [1:0] p0, input logic [1:0] p1,
                                input logic [1:0] head, input logic rdy, input logic v,
                                input logic [31:0] addr, input logic [1:0] pid,
                                input logic [1:0] wf, input logic busy);
        vec_t t;
        t.rst = r; t.flg = flg; t.a0 = a0; t.a1 = a1; t.p0 = p0; t.p1 = p1;
        t.head = head; t.rdy = rdy; t.v = v; t.addr = addr; t.pid = pid;
        t.wf = wf; t.busy = busy;
        return t;
    endfunction

    // Reference model: redirect pipeline expressed as mode + remaining blanking.
    int          m_mode;   // 0 idle, 1 pending, 2 blanking
    logic [31:0] m_addr;
    int          m_pid;
    int          m_left;

    function automatic int agef(input int pid, input int head);
        return (pid - head) & ((1 << PW) - 1);
    endfunction

    function automatic int oldest_way();
        int best = -1;
        for (int i = 0; i < NW; i++)
            if (jumpFlag_i[i] && (best < 0 ||
                agef(int'(EU_pID_i[i]), int'(head_pID_i)) < agef(int'(EU_pID_i[best]), int'(head_pID_i))))
                best = i;
        return best;
    endfunction

    task automatic model_check(input string tag);
        logic [NW-1:0] exp_wf;
        int pend_age;
        pend_age = agef(m_pid, int'(head_pID_i));
        for (int i = 0; i < NW; i++)
            exp_wf[i] = (m_mode == 1) && redirReady_i &&
                        (agef(int'(EU_pID_i[i]), int'(head_pID_i)) > pend_age);
        chk({tag, "_valid"}, 64'(redirValid_o), 64'(m_mode == 1));
        chk({tag, "_addr"},  64'(redirAddr_o),  64'(m_addr));
        chk({tag, "_pid"},   64'(redirPID_o),   64'(m_pid));
        chk({tag, "_flush"}, 64'(wayFlush_o),   64'(exp_wf));
        chk({tag, "_busy"},  64'(busy_o),       64'(m_mode != 0));
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            m_mode = 0; m_addr = '0; m_pid = 0; m_left = 0;
        end else if (m_mode == 0) begin
            w = oldest_way();
            if (w >= 0) begin
                m_mode = 1; m_addr = jumpAddr_i[w]; m_pid = int'(EU_pID_i[w]);
            end
        end else if (m_mode == 1) begin
            w = oldest_way();
            if (redirReady_i) begin
                m_mode = 2; m_left = FC;
            end else if (w >= 0 && agef(int'(EU_pID_i[w]), int'(head_pID_i)) < agef(m_pid, int'(head_pID_i))) begin
                m_addr = jumpAddr_i[w]; m_pid = int'(EU_pID_i[w]);
            end
        end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    vec_t tbl[28];

    initial begin
        int nb;
        tbl[0]  = mk(1, 2'b00, 32'h000, 32'h000, 0, 0, 0, 0,  0, 32'h000, 0, 2'b00, 0);
        tbl[1]  = mk(0, 2'b11, 32'h100, 32'h200, 1, 2, 0, 0,  0, 32'h000, 0, 2'b00, 0);
        tbl[2]  = mk(0, 2'b00, 32'h100, 32'h200, 1, 2, 0, 0,  1, 32'h100, 1, 2'b00, 1);
        tbl[3]  = mk(0, 2'b00, 32'h100, 32'h200, 1, 2, 0, 1,  1, 32'h100, 1, 2'b10, 1);
        tbl[4]  = mk(0, 2'b11, 32'h100, 32'h200, 1, 2, 0, 0,  0, 32'h100, 1, 2'b00, 1);
        tbl[5]  = mk(0, 2'b11, 32'h100, 32'h200, 1, 2, 0, 0,  0, 32'h100, 1, 2'b00, 1);
        tbl[6]  = mk(0, 2'b00, 32'h100, 32'h200, 1, 2, 0, 0,  0, 32'h100, 1, 2'b00, 0);
        tbl[7]  = mk(0, 2'b11, 32'h100, 32'h300, 1, 3, 3, 0,  0, 32'h100, 1, 2'b00, 0);
        tbl[8]  = mk(0, 2'b00, 32'h100, 32'h300, 1, 3, 3, 0,  1, 32'h300, 3, 2'b00, 1);
        tbl[9]  = mk(0, 2'b00, 32'h100, 32'h300, 1, 3, 3, 1,  1, 32'h300, 3, 2'b01, 1);
        tbl[10] = mk(0, 2'b00, 32'h100, 32'h300, 1, 3, 3, 0,  0, 32'h300, 3, 2'b00, 1);
        tbl[11] = mk(0, 2'b00, 32'h100, 32'h300, 1, 3, 3, 0,  0, 32'h300, 3, 2'b00, 1);
        tbl[12] = mk(0, 2'b01, 32'h200, 32'h300, 2, 3, 0, 0,  0, 32'h300, 3, 2'b00, 0);
        tbl[13] = mk(0, 2'b00, 32'h200, 32'h300, 2, 3, 0, 0,  1, 32'h200, 2, 2'b00, 1);
        tbl[14] = mk(0, 2'b10, 32'h200, 32'h080, 2, 1, 0, 0,  1, 32'h200, 2, 2'b00, 1);
        tbl[15] = mk(0, 2'b00, 32'h200, 32'h080, 2, 1, 0, 0,  1, 32'h080, 1, 2'b00, 1);
        tbl[16] = mk(0, 2'b10, 32'h200, 32'h300, 2, 3, 0, 0,  1, 32'h080, 1, 2'b00, 1);
        tbl[17] = mk(0, 2'b00, 32'h200, 32'h300, 2, 3, 0, 0,  1, 32'h080, 1, 2'b00, 1);
        tbl[18] = mk(0, 2'b01, 32'h040, 32'h300, 0, 3, 0, 1,  1, 32'h080, 1, 2'b10, 1);
        tbl[19] = mk(0, 2'b00, 32'h040, 32'h300, 0, 3, 0, 0,  0, 32'h080, 1, 2'b00, 1);
        tbl[20] = mk(0, 2'b00, 32'h040, 32'h300, 0, 3, 0, 0,  0, 32'h080, 1, 2'b00, 1);
        tbl[21] = mk(0, 2'b00, 32'h040, 32'h300, 0, 3, 0, 0,  0, 32'h080, 1, 2'b00, 0);
        tbl[22] = mk(0, 2'b01, 32'h500, 32'h300, 2, 3, 0, 0,  0, 32'h080, 1, 2'b00, 0);
        tbl[23] = mk(1, 2'b00, 32'h500, 32'h300, 2, 3, 0, 0,  1, 32'h500, 2, 2'b00, 1);
        tbl[24] = mk(0, 2'b00, 32'h500, 32'h300, 2, 3, 0, 0,  0, 32'h000, 0, 2'b00, 0);
        tbl[25] = mk(0, 2'b00, 32'h500, 32'h300, 2, 3, 0, 0,  0, 32'h000, 0, 2'b00, 0);
        tbl[26] = mk(1, 2'b01, 32'h700, 32'h300, 1, 3, 0, 0,  0, 32'h000, 0, 2'b00, 0);
        tbl[27] = mk(0, 2'b00, 32'h700, 32'h300, 1, 3, 0, 0,  0, 32'h000, 0, 2'b00, 0);

        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();

        // Directed vectors: one row per clock cycle.
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rst, tbl[i].flg, tbl[i].a0, tbl[i].a1, tbl[i].p0, tbl[i].p1,
                  tbl[i].head, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(redirValid_o), 64'(tbl[i].v));
            chk($sformatf("vec%0d_addr", i),  64'(redirAddr_o),  64'(tbl[i].addr));
            chk($sformatf("vec%0d_pid", i),   64'(redirPID_o),   64'(tbl[i].pid));
            chk($sformatf("vec%0d_flush", i), 64'(wayFlush_o),   64'(tbl[i].wf));
            chk($sformatf("vec%0d_busy", i),  64'(busy_o),       64'(tbl[i].busy));
            next_cycle();
        end

        // Ready already high: accepted on the first PEND cycle, then blanking.
        drive(0, 2'b01, 32'hABC, 32'h0, 0, 0, 0, 1);
        @(negedge clk);
        chk("seq_idle_valid", 64'(redirValid_o), 64'(0));
        next_cycle();
        drive(0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1);
        @(negedge clk);
        chk("seq_accept_valid", 64'(redirValid_o), 64'(1));
        chk("seq_accept_addr", 64'(redirAddr_o), 64'(32'hABC));
        next_cycle();
        drive(0, 2'b11, 32'h1, 32'h2, 0, 0, 0, 1);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_o) break;
            nb++;
            next_cycle();
        end
        chk("seq_blank_cycles", 64'(nb), 64'(FC));
        next_cycle();
        chk("seq_post_blank_valid", 64'(redirValid_o), 64'(1));

        // Randomized run against the reference model.
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        next_cycle();
        m_mode = 0; m_addr = '0; m_pid = 0; m_left = 0;
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom % 64) == 0, 2'($urandom), $urandom, $urandom,
                  2'($urandom), 2'($urandom), 2'($urandom), ($urandom % 3) == 0);
            @(negedge clk);
            model_check("rnd");
            model_step();
            next_cycle();
        end

`ifdef JUMP_ARB_STATS_EN
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 2'b01, 32'h10, 0, 2, 0, 0, 0); next_cycle();
        drive(0, 2'b01, 32'h20, 0, 1, 0, 0, 0); next_cycle();
        drive(0, 2'b00, 32'h0, 0, 0, 0, 0, 1);  next_cycle();
        drive(0, 2'b00, 32'h0, 0, 0, 0, 0, 0);  repeat (FC) next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(0, 2'b01, 32'h30, 0, 1, 0, 0, 0); next_cycle();
            drive(0, 2'b00, 32'h0, 0, 0, 0, 0, 1);  next_cycle();
            drive(0, 2'b00, 32'h0, 0, 0, 0, 0, 0);  repeat (FC) next_cycle();
        end
        @(negedge clk);
        chk("stats_redir", 64'(redirCnt_o), 64'(3));
        chk("stats_drop",  64'(dropCnt_o),  64'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jump_redirect_arb.md
JUMP_REDIRECT_ARB -- requirements
Module: jump_redirect_arb

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 2: number of execute ways reporting jumps (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32: jump-target width.
REQ-003 SHALL have parameter PID_W, default 2: program-order ID width; IDs are modulo 2^PID_W.
REQ-004 SHALL have parameter FLUSH_CYC, default 2: wrong-path blanking cycles after an accepted redirect (1..15).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port jumpFlag_i, input, NUM_WAYS: per-way jump taken.
REQ-008 SHALL have port jumpAddr_i, input, NUM_WAYS x ADDR_W: per-way jump target.
REQ-009 SHALL have port EU_pID_i, input, NUM_WAYS x PID_W: per-way program-order ID.
REQ-010 SHALL have port head_pID_i, input, PID_W: ID of oldest in-flight instruction.
REQ-011 SHALL have port redirValid_o, output, 1: redirect pending to fetch.
REQ-012 SHALL have port redirReady_i, input, 1: fetch accepts redirect.
REQ-013 SHALL have port redirAddr_o, output, ADDR_W: redirect target.
REQ-014 SHALL have port redirPID_o, output, PID_W: ID of the winning jump.
REQ-015 SHALL have port wayFlush_o, output, NUM_WAYS: one-cycle pulse per way, on the acceptance cycle, for ways holding IDs younger than redirPID_o.
REQ-016 SHALL have port busy_o, output, 1: high when state is not IDLE.

Function
REQ-017 SHALL compute per-way age = (EU_pID_i - head_pID_i) mod 2^PID_W; a smaller age is older.
REQ-018 SHALL select the oldest way with its flag set; on equal ages the lowest way index wins.
REQ-019 SHALL have states IDLE, PEND and FLUSH.
REQ-020 IDLE: on any flag set, SHALL register winner addr/pID and enter PEND next cycle; latency from flag to redirValid_o is 1 cycle.
REQ-021 PEND: SHALL hold redirValid_o=1 with redirAddr_o/redirPID_o stable until redirValid_o & redirReady_i.
REQ-022 PEND: a new winner whose age is strictly smaller than that of the pending pID (both measured from the current head_pID_i) SHALL replace the pending addr/pID; otherwise it SHALL be dropped.
REQ-023 PEND with replacement and redirReady_i=1 in the same cycle: the old redirect SHALL be accepted, the new one SHALL be dropped (it is on the wrong path), and the FSM SHALL enter FLUSH.
REQ-024 On acceptance SHALL pulse wayFlush_o, load a blanking counter with FLUSH_CYC, and enter FLUSH.
REQ-025 FLUSH: SHALL ignore all flags, decrement the counter each cycle, and return to IDLE when it reaches 0 (FLUSH_CYC cycles in FLUSH).
REQ-026 redirValid_o SHALL be 0 in IDLE and FLUSH; redirAddr_o and redirPID_o SHALL keep their last values outside PEND.
REQ-027 The ID wrap-around SHALL be handled by REQ-017 only; no extra wrap bit is used.

Reset
REQ-028 On rst=1 at a clock edge SHALL force IDLE, counter=0, redirValid_o=0, redirAddr_o=0, redirPID_o=0, wayFlush_o=0, busy_o=0.
REQ-029 Reset asserted in PEND or FLUSH SHALL discard the pending redirect; flags sampled during reset SHALL be ignored.

Configuration
REQ-030 With JUMP_ARB_STATS_EN defined, SHALL add 32-bit outputs redirCnt_o (accepted redirects) and dropCnt_o (replaced plus dropped requests); both reset to 0 and saturate at all-ones.
REQ-031 Without JUMP_ARB_STATS_EN, these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-032 Package b8_jump_pkg SHALL hold the state enum (IDLE/PEND/FLUSH), the jump_req_t struct (flag, addr, pID) and default parameter constants.
REQ-033 The oldest-select logic SHALL be sub-module jump_age_sel (combinational, parameterised by NUM_WAYS/PID_W; outputs found, winner index, addr, pID).

Verification
REQ-034 Bench SHALL check: head=0, way0 pID=1 flag addr 0x100, way1 pID=2 flag addr 0x200 -> next cycle redirValid_o=1, redirAddr_o=0x100, redirPID_o=1.
REQ-035 Bench SHALL check: head=3, way0 pID=1 addr 0x100, way1 pID=3 addr 0x300 (wrap) -> redirAddr_o=0x300, redirPID_o=3.
REQ-036 Bench SHALL check: PEND pID=2 addr 0x200, ready=0; way1 pID=1 addr 0x80 flags -> redirAddr_o becomes 0x80 next cycle; younger pID=3 -> unchanged.
REQ-037 Bench SHALL check: accept with pID=1 while ways hold pIDs 1 and 2 -> wayFlush_o=2'b10 for one cycle; flags ignored for FLUSH_CYC=2 cycles, then IDLE.
REQ-038 Bench SHALL check: rst=1 in PEND -> next cycle redirValid_o=0 and busy_o=0; the held redirect is never presented.
REQ-039 Bench SHALL check (with JUMP_ARB_STATS_EN): 3 accepts and 1 replacement -> redirCnt_o=3, dropCnt_o=1.
